store_monitor: RTL

Synthesizable store-side responder for the MIPS data bus. It sits beside `top` and observes every CPU store (`memwrite`, `dataadr`, `writedata`). It decides pass/fail on-chip: pass when a store matches a programmed address/data pair, fail when a watchdog cycle limit expires first. Mismatching stores are kept in a small FIFO that the host drains, so a test program can be self-checked in hardware or on an FPGA without a simulator-side checker.

---
 rtl/store_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/store_monitor.sv
// store_monitor: watches CPU stores, declares pass on a programmed
// address/data match or fail on a RUN-cycle watchdog, and logs
// mismatching stores in a small FIFO that the host drains.
module store_monitor #(
    parameter logic [31:0] EXP_ADR   = 32'h0000_0012,
    parameter logic [31:0] EXP_DATA  = 32'h0000_00ff,
    parameter int          TIMEOUT   = 100,
    parameter int          LOG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        start,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [31:0] cycles,
    output logic [7:0]  store_count,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    input  logic        log_pop,
    output logic        log_overflow
);

    localparam int          PW         = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int          CW         = PW + 1;
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // Exact 32-bit equality on both fields of a store.
    function automatic logic is_match(input logic [31:0] adr, input logic [31:0] data);
        return (adr == EXP_ADR) && (data == EXP_DATA);
    endfunction

    state_t          state_r, state_s;
    logic [31:0]     cycles_r;
    logic [7:0]      store_count_r;
    logic            done_r, pass_r, fail_r;
    logic            overflow_r;
    logic            log_valid_r;
    logic [31:0]     log_adr_r, log_data_r;
    logic [63:0]     mem_r [LOG_DEPTH];
    logic [PW-1:0]   rd_r, wr_r, rd_s, wr_s;
    logic [CW-1:0]   count_r, count_s;
    logic [63:0]     head_s;
    logic            run_s, store_s, match_s, push_req_s, push_s, pop_s, full_s, drop_s;

    // Qualify stores and FIFO handshakes for this cycle.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        match_s    = is_match(dataadr, writedata);
        store_s    = run_s && memwrite && !start;
        push_req_s = store_s && !match_s;
        pop_s      = log_pop && (count_r != '0);
        full_s     = (count_r == DEPTH_C);
        // A pop in the same cycle frees the slot the push needs.
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;
    end

    // Next-state logic; a match beats the watchdog on the same edge.
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (store_s && match_s) begin
                        state_s = ST_PASS;
                    end else if (cycles_r == TIMEOUT_M1) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_PASS: state_s = ST_PASS;
                ST_FAIL: state_s = ST_FAIL;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FIFO pointer/count update and the head entry as it will look after this edge.
    always_comb begin
        if (start) begin
            rd_s    = '0;
            wr_s    = '0;
            count_s = '0;
        end else begin
            rd_s    = rd_r + PW'(pop_s);
            wr_s    = wr_r + PW'(push_s);
            count_s = count_r + CW'(push_s) - CW'(pop_s);
        end
        // The entry being written becomes head when the FIFO would otherwise be empty.
        if (push_s && (wr_r == rd_s)) begin
            head_s = {dataadr, writedata};
        end else begin
            head_s = mem_r[rd_s];
        end
    end

    // Control state, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cycles_r      <= 32'd0;
            store_count_r <= 8'd0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            overflow_r    <= 1'b0;
            rd_r          <= '0;
            wr_r          <= '0;
            count_r       <= '0;
            log_valid_r   <= 1'b0;
            log_adr_r     <= 32'd0;
            log_data_r    <= 32'd0;
        end else begin
            state_r     <= state_s;
            pass_r      <= (state_s == ST_PASS);
            fail_r      <= (state_s == ST_FAIL);
            done_r      <= (state_s == ST_PASS) || (state_s == ST_FAIL);
            rd_r        <= rd_s;
            wr_r        <= wr_s;
            count_r     <= count_s;
            log_valid_r <= (count_s != '0);
            log_adr_r   <= head_s[63:32];
            log_data_r  <= head_s[31:0];
            if (start) begin
                cycles_r      <= 32'd0;
                store_count_r <= 8'd0;
                overflow_r    <= 1'b0;
            end else begin
                if (run_s) begin
                    cycles_r <= cycles_r + 32'd1;
                end
                if (store_s && (store_count_r != 8'hff)) begin
                    store_count_r <= store_count_r + 8'd1;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // Mismatch log storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
        end else if (push_s) begin
            mem_r[wr_r] <= {dataadr, writedata};
        end
    end

    assign done         = done_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign cycles       = cycles_r;
    assign store_count  = store_count_r;
    assign log_valid    = log_valid_r;
    assign log_adr      = log_adr_r;
    assign log_data     = log_data_r;
    assign log_overflow = overflow_r;

endmodule
